// File: rtl/cpu_types_pkg.sv
// Shared CPU types for the instruction cache: word type, frame layout at the
// default geometry, and the fill FSM state encoding.
package cpu_types_pkg;
    typedef logic [31:0] word_t;

    localparam int ICACHE_SETS = 16;
    localparam int IIDX_W      = 4;
    localparam int ITAG_W      = 26;

    typedef struct packed {
        logic              valid;
        logic [ITAG_W-1:0] tag;
        word_t             data;
    } icache_frame_t;

    typedef enum logic {IDLE, FETCH} icache_state_t;
endpackage

// File: rtl/icache_if.sv
// Datapath fetch port and memory-side fill port of the instruction cache.
interface icache_if;
    import cpu_types_pkg::*;

    logic  imemREN;
    word_t imemaddr;
    logic  halt;
    logic  ihit;
    word_t imemload;
    logic  iREN;
    word_t iaddr;
    logic  iwait;
    word_t iload;

    modport slave (
        input  imemREN, imemaddr, halt, iwait, iload,
        output ihit, imemload, iREN, iaddr
    );

    modport master (
        output imemREN, imemaddr, halt, iwait, iload,
        input  ihit, imemload, iREN, iaddr
    );
endinterface

// File: rtl/icache.sv
// Direct-mapped, one-word-per-frame instruction cache with a blocking
// two-state fill FSM and free-running hit/miss counters.
module icache
    import cpu_types_pkg::*;
#(
    parameter int SETS = ICACHE_SETS
) (
    input  logic      CLK,
    input  logic      nRST,
    icache_if.slave   bus,
    output word_t     hit_count,
    output word_t     miss_count
);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 30 - IDX_W;

    icache_state_t    state_q, state_d;
    word_t            miss_addr_q, miss_addr_d;
    word_t            hit_count_q, hit_count_d;
    word_t            miss_count_q, miss_count_d;
    logic [SETS-1:0]  valid_q, valid_d;
    logic [TAG_W-1:0] tag_q  [SETS];
    word_t            data_q [SETS];

    logic [IDX_W-1:0] req_idx, fill_idx;
    logic [TAG_W-1:0] req_tag, tag_d;
    word_t            data_d;
    logic             fill_en;
    logic             ihit;
    word_t            imemload;
    logic             iren;
    word_t            iaddr;
    logic             unused_lsb;

    assign req_idx    = bus.imemaddr[IDX_W+1:2];
    assign req_tag    = bus.imemaddr[31:IDX_W+2];
    assign fill_idx   = miss_addr_q[IDX_W+1:2];
    assign tag_d      = miss_addr_q[31:IDX_W+2];
    assign data_d     = bus.iload;
    assign unused_lsb = ^{bus.imemaddr[1:0], miss_addr_q[1:0]};

    always_comb begin
        state_d      = state_q;
        miss_addr_d  = miss_addr_q;
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        valid_d      = valid_q;
        fill_en      = 1'b0;
        ihit         = 1'b0;
        imemload     = '0;
        iren         = 1'b0;
        iaddr        = '0;
        case (state_q)
            IDLE: begin
                ihit = bus.imemREN & valid_q[req_idx] & (tag_q[req_idx] == req_tag);
                if (ihit) imemload = data_q[req_idx];
                // halt only gates new fills; hits keep flowing
                if (bus.imemREN && !ihit && !bus.halt) begin
                    state_d      = FETCH;
                    miss_addr_d  = bus.imemaddr;
                    miss_count_d = miss_count_q + 32'd1;
                end
            end
            FETCH: begin
                iren  = 1'b1;
                iaddr = {miss_addr_q[31:2], 2'b00};
                if (!bus.iwait) begin
                    state_d           = IDLE;
                    fill_en           = 1'b1;
                    valid_d[fill_idx] = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (ihit) hit_count_d = hit_count_q + 32'd1;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q      <= IDLE;
            miss_addr_q  <= '0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
            valid_q      <= '0;
        end else begin
            state_q      <= state_d;
            miss_addr_q  <= miss_addr_d;
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
            valid_q      <= valid_d;
        end
    end

    // Tag/data carry no reset: valid bits alone decide whether a frame is live.
    always_ff @(posedge CLK) begin
        if (fill_en) begin
            tag_q[fill_idx]  <= tag_d;
            data_q[fill_idx] <= data_d;
        end
    end

    assign bus.ihit     = ihit;
    assign bus.imemload = imemload;
    assign bus.iREN     = iren;
    assign bus.iaddr    = iaddr;
    assign hit_count    = hit_count_q;
    assign miss_count   = miss_count_q;
endmodule

// File: tb/tb_icache.sv
// Scenario bench for icache: expected values are queued as stimulus is driven
// and drained against the DUT mid-cycle.
module tb_icache;
    logic        CLK;
    logic        nRST;
    logic [31:0] hit_count, miss_count;
    int          vectors, miscompares;

    typedef struct {
        string       tag;
        logic [31:0] v;
    } sb_t;
    sb_t sb[$];

    icache_if bus ();

    icache #(.SETS(16)) dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .bus        (bus),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic push(input string t, input logic [31:0] v);
        sb_t e;
        e.tag = t;
        e.v   = v;
        sb.push_back(e);
    endtask

    task automatic sample();
        sb_t e;
        #3;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.tag)
                "ihit":  chk(e.tag, {31'b0, bus.ihit}, e.v);
                "load":  chk(e.tag, bus.imemload, e.v);
                "iren":  chk(e.tag, {31'b0, bus.iREN}, e.v);
                "iaddr": chk(e.tag, bus.iaddr, e.v);
                "hitc":  chk(e.tag, hit_count, e.v);
                "missc": chk(e.tag, miss_count, e.v);
                default: chk({"badtag_", e.tag}, 32'h0, 32'h1);
            endcase
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        nRST         = 1'b0;
        bus.imemREN  = 1'b0;
        bus.imemaddr = '0;
        bus.halt     = 1'b0;
        bus.iwait    = 1'b1;
        bus.iload    = '0;
        #1;
        push("ihit", 0); push("load", 0); push("iren", 0); push("iaddr", 0);
        push("hitc", 0); push("missc", 0);
        sample();
        tick();
        tick();
        nRST = 1'b1;
        tick();
    endtask

    task automatic fill(input logic [31:0] addr, input logic [31:0] data, input int nwait);
        bus.imemREN  = 1'b1;
        bus.imemaddr = addr;
        bus.iwait    = 1'b1;
        push("ihit", 0); push("iren", 0);
        sample();
        tick();
        for (int i = 0; i < nwait; i++) begin
            push("iren", 1); push("iaddr", addr & ~32'h3); push("ihit", 0);
            sample();
            tick();
        end
        bus.iwait = 1'b0;
        bus.iload = data;
        push("iren", 1); push("iaddr", addr & ~32'h3); push("ihit", 0);
        sample();
        tick();
        bus.iwait = 1'b1;
        push("ihit", 1); push("load", data); push("iren", 0);
        sample();
        tick();
        bus.imemREN = 1'b0;
    endtask

    task automatic fetch_hit(input logic [31:0] addr, input logic [31:0] data);
        bus.imemREN  = 1'b1;
        bus.imemaddr = addr;
        push("ihit", 1); push("load", data); push("iren", 0);
        sample();
        tick();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;

        // cold miss with two busy cycles
        do_reset();
        fill(32'h40, 32'h8C22_0004, 2);
        push("hitc", 1); push("missc", 1); push("iren", 0);
        sample();

        // hit stream
        do_reset();
        fill(32'h0, 32'h1111_0000, 0);
        fill(32'h4, 32'h1111_0004, 0);
        fill(32'h8, 32'h1111_0008, 0);
        push("hitc", 3); push("missc", 3);
        sample();
        tick();
        fetch_hit(32'h0, 32'h1111_0000);
        fetch_hit(32'h4, 32'h1111_0004);
        fetch_hit(32'h8, 32'h1111_0008);
        bus.imemREN  = 1'b0;
        bus.imemaddr = 32'h0;
        push("ihit", 0); push("load", 0); push("hitc", 6); push("missc", 3);
        sample();
        tick();

        // conflict eviction at index 0
        do_reset();
        fill(32'h00, 32'hAAAA_AAAA, 0);
        fill(32'h40, 32'hBBBB_BBBB, 0);
        bus.imemREN  = 1'b1;
        bus.imemaddr = 32'h0;
        bus.iwait    = 1'b1;
        push("ihit", 0);
        sample();
        tick();
        push("iren", 1); push("iaddr", 32'h0); push("missc", 3); push("ihit", 0);
        sample();
        tick();
        bus.iwait = 1'b0;
        bus.iload = 32'hAAAA_AAAA;
        tick();
        bus.iwait = 1'b1;
        push("ihit", 1); push("load", 32'hAAAA_AAAA);
        sample();
        tick();
        bus.imemREN = 1'b0;

        // halt: hits served, misses stall without fill
        do_reset();
        fill(32'h10, 32'hDDDD_0010, 0);
        bus.halt = 1'b1;
        fetch_hit(32'h10, 32'hDDDD_0010);
        bus.imemaddr = 32'h20;
        bus.iwait    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push("ihit", 0); push("iren", 0); push("missc", 1);
            sample();
            tick();
        end
        push("hitc", 2);
        sample();
        bus.halt    = 1'b0;
        bus.imemREN = 1'b0;
        tick();

        // reset mid-fill
        do_reset();
        bus.imemREN  = 1'b1;
        bus.imemaddr = 32'h80;
        bus.iwait    = 1'b1;
        push("ihit", 0);
        sample();
        tick();
        push("iren", 1); push("iaddr", 32'h80);
        sample();
        nRST = 1'b0;
        #1;
        push("iren", 0); push("iaddr", 0); push("missc", 0); push("ihit", 0);
        sample();
        tick();
        nRST      = 1'b1;
        bus.iwait = 1'b0;
        bus.iload = 32'h8080_8080;
        push("ihit", 0); push("missc", 0);
        sample();
        tick();
        push("iren", 1); push("iaddr", 32'h80); push("missc", 1);
        sample();
        tick();
        push("ihit", 1); push("load", 32'h8080_8080);
        sample();
        tick();
        bus.imemREN = 1'b0;

        // address change during fetch does not redirect the fill
        do_reset();
        bus.imemREN  = 1'b1;
        bus.imemaddr = 32'h100;
        bus.iwait    = 1'b1;
        push("ihit", 0);
        sample();
        tick();
        bus.imemaddr = 32'h104;
        push("iren", 1); push("iaddr", 32'h100); push("ihit", 0);
        sample();
        tick();
        bus.iwait = 1'b0;
        bus.iload = 32'h0100_CAFE;
        push("iren", 1); push("iaddr", 32'h100);
        sample();
        tick();
        bus.iwait = 1'b1;
        push("ihit", 0); push("iren", 0); push("missc", 1);
        sample();
        bus.imemaddr = 32'h100;
        push("ihit", 1); push("load", 32'h0100_CAFE);
        sample();
        tick();
        bus.imemREN = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
